seed_gen: RTL and testbench

SEED_GEN -- requirements
Module: seed_gen

---
 rtl/seed_gen.sv | 128 ++++++++++++
 tb/tb_seed_gen.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/seed_gen.sv
// -----------------------------------------------------------------------------
// seed_gen
//   Produces a seed word from a free-running basis register. The basis counts
//   up or steps a Galois LFSR, and it advances on every clock edge where
//   run=1. A two-state capture FSM latches the pattern {~basis, basis}, which
//   is repeated to fill SEED_W. It holds that word until the consumer
//   acknowledges it.
//
// Ports
//   clk          in   1        sole clock, rising edge
//   reset        in   1        asynchronous clear, active low
//   rst_seedgen  in   1        synchronous clear, active high, highest priority
//   mode         in   1        0 = counter, 1 = LFSR
//   run          in   1        basis advance enable
//   cap_req      in   1        capture request (honoured in IDLE only)
//   cap_ack      in   1        consumer acknowledge (honoured in VALID only)
//   basis        out  BASIS_W  live basis register
//   seed         out  SEED_W   captured seed, stable while seed_valid=1
//   seed_valid   out  1        captured seed available
//
// Capture FSM
//   state | meaning
//   IDLE  | no seed held; cap_req loads the pattern and moves to VALID
//   VALID | seed held; cap_ack releases it, cap_req is ignored
// -----------------------------------------------------------------------------
module seed_gen #(
    parameter int                  BASIS_W   = 8,
    parameter int                  SEED_W    = 32,
    parameter logic [BASIS_W-1:0]  LFSR_TAPS = 8'hB8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rst_seedgen,
    input  logic               mode,
    input  logic               run,
    input  logic               cap_req,
    input  logic               cap_ack,
    output logic [BASIS_W-1:0] basis,
    output logic [SEED_W-1:0]  seed,
    output logic               seed_valid
);

    localparam int REPS = SEED_W / (2 * BASIS_W);

    if (BASIS_W < 4 || BASIS_W > 16) begin : g_bad_basis_w
        $error("seed_gen: BASIS_W must lie in 4..16");
    end
    if ((SEED_W % (2 * BASIS_W)) != 0 || SEED_W == 0) begin : g_bad_seed_w
        $error("seed_gen: SEED_W must be a non-zero multiple of 2*BASIS_W");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        VALID = 1'b1
    } state_t;

    localparam logic [BASIS_W-1:0] ONE = {{(BASIS_W-1){1'b0}}, 1'b1};

    state_t             state_q, state_next;
    logic [BASIS_W-1:0] basis_q, basis_next;
    logic [SEED_W-1:0]  seed_q, seed_next;
    logic [BASIS_W-1:0] lfsr_step;
    logic [SEED_W-1:0]  pattern;

    assign lfsr_step = (basis_q >> 1) ^ (basis_q[0] ? LFSR_TAPS : '0);
    assign pattern   = {REPS{~basis_q, basis_q}};

    // The basis update does not depend on the FSM. A mode change only
    // selects which rule the next advance uses.
    always_comb begin
        basis_next = basis_q;
        if (rst_seedgen) begin
            basis_next = '0;
        end else if (run) begin
            if (mode) begin
                // All-zero is the LFSR lockup state, so it is forced out to 1.
                basis_next = (basis_q == '0) ? ONE : lfsr_step;
            end else begin
                basis_next = basis_q + ONE;
            end
        end
    end

    always_comb begin
        state_next = state_q;
        seed_next  = seed_q;
        if (rst_seedgen) begin
            state_next = IDLE;
            seed_next  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cap_req) begin
                        seed_next  = pattern;
                        state_next = VALID;
                    end
                end
                VALID: begin
                    // When cap_req and cap_ack arrive together, the acknowledge
                    // wins and no capture happens until the FSM is back in IDLE.
                    if (cap_ack) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            basis_q <= '0;
            seed_q  <= '0;
        end else begin
            state_q <= state_next;
            basis_q <= basis_next;
            seed_q  <= seed_next;
        end
    end

    assign basis      = basis_q;
    assign seed       = seed_q;
    assign seed_valid = (state_q == VALID);

endmodule

// File: tb/tb_seed_gen.sv
module tb_seed_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        rst_seedgen, mode, run, cap_req, cap_ack;
    logic [7:0]  basis;
    logic [31:0] seed;
    logic        seed_valid;

    logic        rst_seedgen4, mode4, run4, cap_req4, cap_ack4;
    logic [3:0]  basis4;
    logic [23:0] seed4;
    logic        seed_valid4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seed_gen dut (
        .clk(clk), .reset(reset), .rst_seedgen(rst_seedgen), .mode(mode),
        .run(run), .cap_req(cap_req), .cap_ack(cap_ack),
        .basis(basis), .seed(seed), .seed_valid(seed_valid)
    );

    seed_gen #(.BASIS_W(4), .SEED_W(24), .LFSR_TAPS(4'hC)) dut4 (
        .clk(clk), .reset(reset), .rst_seedgen(rst_seedgen4), .mode(mode4),
        .run(run4), .cap_req(cap_req4), .cap_ack(cap_ack4),
        .basis(basis4), .seed(seed4), .seed_valid(seed_valid4)
    );

    typedef struct {
        logic        mode;
        logic        run;
        logic        req;
        logic        ack;
        logic [7:0]  eb;
        logic        ev;
        logic [31:0] es;
    } vec_t;

    vec_t        vecs[11];
    logic [31:0] sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst_seedgen = 0; mode = 0; run = 0; cap_req = 0; cap_ack = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        #2 reset = 0;
        step();
        reset = 1;
    endtask

    function automatic logic [31:0] pat8(input logic [7:0] b);
        return {~b, b, ~b, b};
    endfunction

    initial begin
        logic [7:0] prev_b;
        logic       prev_ev;
        logic       prev_dv;
        logic [7:0] lseq[6];
        logic [31:0] held;

        reset = 1;
        idle_inputs();
        rst_seedgen4 = 0; mode4 = 0; run4 = 0; cap_req4 = 0; cap_ack4 = 0;
        #3 reset = 0;
        #1;
        check("reset_basis", {24'h0, basis}, 32'h0);
        check("reset_valid", {31'h0, seed_valid}, 32'h0);
        check("reset_seed", seed, 32'h0);
        step();
        reset = 1;

        // mode run req ack | basis valid seed
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h01, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h02, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h03, 1'b0, 32'h0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h03, 1'b1, 32'hFC03FC03};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h04, 1'b1, 32'hFC03FC03};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h05, 1'b0, 32'hFC03FC03};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h05, 1'b0, 32'hFC03FC03};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'hBA, 1'b0, 32'hFC03FC03};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h5D, 1'b1, 32'h45BA45BA};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h5E, 1'b1, 32'h45BA45BA};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h5E, 1'b0, 32'h45BA45BA};

        prev_b = 8'h00; prev_ev = 1'b0; prev_dv = seed_valid;
        for (int i = 0; i < 11; i++) begin
            mode = vecs[i].mode; run = vecs[i].run;
            cap_req = vecs[i].req; cap_ack = vecs[i].ack;
            if (vecs[i].req && !prev_ev) sb_q.push_back(pat8(prev_b));
            step();
            check($sformatf("vec%0d_basis", i), {24'h0, basis}, {24'h0, vecs[i].eb});
            check($sformatf("vec%0d_valid", i), {31'h0, seed_valid}, {31'h0, vecs[i].ev});
            check($sformatf("vec%0d_seed", i), seed, vecs[i].es);
            if (!prev_dv && seed_valid) begin
                if (sb_q.size() == 0) check("sb_unexpected_capture", 32'h1, 32'h0);
                else check($sformatf("sb_capture_vec%0d", i), seed, sb_q.pop_front());
            end
            prev_dv = seed_valid; prev_b = vecs[i].eb; prev_ev = vecs[i].ev;
        end
        check("sb_empty", sb_q.size(), 32'h0);

        // counter wrap
        do_reset();
        mode = 0; run = 1;
        repeat (255) step();
        check("wrap_ff", {24'h0, basis}, 32'hFF);
        step();
        check("wrap_00", {24'h0, basis}, 32'h00);

        // LFSR sequence including lockup escape
        do_reset();
        lseq = '{8'h00, 8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17};
        check("lfsr_0", {24'h0, basis}, {24'h0, lseq[0]});
        mode = 1; run = 1;
        for (int i = 1; i < 6; i++) begin
            step();
            check($sformatf("lfsr_%0d", i), {24'h0, basis}, {24'h0, lseq[i]});
        end

        // handshake hold
        do_reset();
        mode = 0; run = 1;
        repeat (5) step();
        run = 0; cap_req = 1;
        step();
        check("hold_cap_valid", {31'h0, seed_valid}, 32'h1);
        check("hold_cap_seed", seed, 32'hFA05FA05);
        run = 1;
        held = 32'hFA05FA05;
        for (int i = 0; i < 10; i++) begin
            step();
            if (seed !== held || seed_valid !== 1'b1) check($sformatf("hold_cyc%0d", i), seed, held);
        end
        check("hold_seed_end", seed, 32'hFA05FA05);
        check("hold_basis_end", {24'h0, basis}, 32'h0F);
        cap_ack = 1;
        step();
        check("ack_valid", {31'h0, seed_valid}, 32'h0);
        cap_ack = 0;
        step();
        check("recap_valid", {31'h0, seed_valid}, 32'h1);
        check("recap_seed", seed, 32'hEF10EF10);

        // async reset between edges while VALID
        #2 reset = 0;
        #1;
        check("async_valid", {31'h0, seed_valid}, 32'h0);
        check("async_seed", seed, 32'h0);
        check("async_basis", {24'h0, basis}, 32'h0);
        idle_inputs();
        step();
        reset = 1;

        // synchronous clear beats cap_req
        mode = 0; run = 1;
        repeat (64) step();
        check("clr_pre_basis", {24'h0, basis}, 32'h40);
        rst_seedgen = 1; cap_req = 1;
        step();
        check("clr_basis", {24'h0, basis}, 32'h0);
        check("clr_valid", {31'h0, seed_valid}, 32'h0);
        check("clr_seed", seed, 32'h0);
        rst_seedgen = 0; cap_req = 0; run = 0;
        step();
        check("clr_valid_after", {31'h0, seed_valid}, 32'h0);

        // 4-bit basis, 24-bit seed
        mode4 = 0; run4 = 1;
        repeat (3) step();
        check("p4_basis", {28'h0, basis4}, 32'h3);
        run4 = 0; cap_req4 = 1;
        step();
        check("p4_valid", {31'h0, seed_valid4}, 32'h1);
        check("p4_seed", {8'h0, seed4}, 32'h00C3C3C3);
        cap_req4 = 0; mode4 = 1; run4 = 1;
        step();
        check("p4_lfsr", {28'h0, basis4}, 32'hD);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: sim time limit reached");
        $fatal(1, "timeout");
    end

endmodule
